// File: rtl/inst_fetch_pkg.sv
// Shared fetch-stage types and constants.
// Fetch FSM encoding, reset PC default and common word/bool literals.
package inst_fetch_pkg;

  typedef enum logic [1:0] {
    IF_LOOKUP = 2'd0,
    IF_FETCH  = 2'd1,
    IF_WRITE  = 2'd2
  } if_state_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;
  localparam logic        True_v       = 1'b1;
  localparam logic        False_v      = 1'b0;

  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch.sv
// IF stage: owns the PC, looks it up in the I-cache, fills misses
// byte by byte from memory and feeds {pc, inst} to the IF/ID register.
//
// Ports:
//   clk, rst (sync, active-low), rdy (global run enable)
//   stall_i, branch_i, branch_target_i : downstream control / redirect
//   cache_rpc_o, cache_hit_i, cache_inst_i : cache lookup
//   cache_we_o, cache_wpc_o, cache_winst_o : cache fill write
//   mem_req_o, mem_addr_o, mem_ack_i, mem_data_i : byte memory port
//   if_pc_o, if_inst_o, if_valid_o : fetched instruction
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] cache_rpc_o,
  input  logic        cache_hit_i,
  input  logic [31:0] cache_inst_i,
  output logic        cache_we_o,
  output logic [31:0] cache_wpc_o,
  output logic [31:0] cache_winst_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [7:0]  mem_data_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        if_valid_o
);

  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] fill_q, fill_d;
  logic        pend_q, pend_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic        if_valid_q, if_valid_d;

  logic [31:0] br_tgt;
  logic        unused_tgt_lsb;

  assign br_tgt         = word_align(branch_target_i);
  assign unused_tgt_lsb = ^branch_target_i[1:0];

  assign cache_rpc_o   = pc_q;
  assign cache_wpc_o   = pc_q;
  assign cache_winst_o = fill_q;
  assign mem_addr_o    = pc_q + {30'b0, cnt_q};
  assign if_pc_o       = if_pc_q;
  assign if_inst_o     = if_inst_q;
  assign if_valid_o    = if_valid_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    fill_d     = fill_q;
    pend_d     = pend_q;
    tgt_d      = tgt_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
    if_valid_d = if_valid_q;
    mem_req_o  = False_v;
    cache_we_o = False_v;

    if (rdy) begin
      unique case (state_q)
        IF_LOOKUP: begin
          if (branch_i) begin
            pc_d       = br_tgt;
            if_valid_d = False_v;
          end else if (cache_hit_i) begin
            if (!stall_i) begin
              if_pc_d    = pc_q;
              if_inst_d  = cache_inst_i;
              if_valid_d = True_v;
              pc_d       = pc_q + 32'd4;
            end
          end else begin
            if (!stall_i) if_valid_d = False_v;
            state_d = IF_FETCH;
            cnt_d   = 2'd0;
          end
        end

        IF_FETCH: begin
          mem_req_o = True_v;
          // A held output is consumed once stall drops; never re-offer it.
          if (!stall_i || branch_i) if_valid_d = False_v;
          if (branch_i) begin
            pend_d = True_v;
            tgt_d  = br_tgt;
          end
          if (mem_ack_i) begin
            if (branch_i || pend_q) begin
              // Outstanding byte retired: abandon the fill.
              pc_d       = branch_i ? br_tgt : tgt_q;
              state_d    = IF_LOOKUP;
              cnt_d      = 2'd0;
              pend_d     = False_v;
              fill_d     = ZeroWord;
              if_valid_d = False_v;
            end else begin
              fill_d[{cnt_q, 3'b000} +: 8] = mem_data_i;
              cnt_d = cnt_q + 2'd1;
              if (cnt_q == 2'd3) state_d = IF_WRITE;
            end
          end
        end

        IF_WRITE: begin
          cache_we_o = True_v;
          state_d    = IF_LOOKUP;
          if (!stall_i || branch_i) if_valid_d = False_v;
          if (branch_i) pc_d = br_tgt;
        end

        default: state_d = IF_LOOKUP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IF_LOOKUP;
      pc_q       <= RESET_PC;
      cnt_q      <= 2'd0;
      fill_q     <= ZeroWord;
      pend_q     <= False_v;
      tgt_q      <= ZeroWord;
      if_pc_q    <= ZeroWord;
      if_inst_q  <= ZeroWord;
      if_valid_q <= False_v;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      fill_q     <= fill_d;
      pend_q     <= pend_d;
      tgt_q      <= tgt_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
      if_valid_q <= if_valid_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus a
// randomized run scored against a PC-stream / memory reference model.
module tb_inst_fetch;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        stall_i;
  logic        branch_i;
  logic [31:0] branch_target_i;
  logic [31:0] cache_rpc_o;
  logic        cache_hit_i;
  logic [31:0] cache_inst_i;
  logic        cache_we_o;
  logic [31:0] cache_wpc_o;
  logic [31:0] cache_winst_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [7:0]  mem_data_i;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        if_valid_o;

  inst_fetch dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .stall_i(stall_i), .branch_i(branch_i),
    .branch_target_i(branch_target_i),
    .cache_rpc_o(cache_rpc_o),
    .cache_hit_i(cache_hit_i),
    .cache_inst_i(cache_inst_i),
    .cache_we_o(cache_we_o),
    .cache_wpc_o(cache_wpc_o),
    .cache_winst_o(cache_winst_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
    .if_pc_o(if_pc_o), .if_inst_o(if_inst_o),
    .if_valid_o(if_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_acc   = 0;

  logic [31:0] cmem [logic [31:0]];
  logic [31:0] ack_log[$];
  logic [31:0] we_log[$];
  logic [31:0] exp_pc;
  logic        req_pend;
  logic [31:0] req_addr;

  logic        r_rst, r_rdy, r_stall, r_branch;
  logic [31:0] r_tgt;
  int          r_ack;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memword(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0513;
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [7:0] memb(input logic [31:0] a);
    logic [31:0] w;
    w = memword({a[31:2], 2'b00});
    return w[{a[1:0], 3'b000} +: 8];
  endfunction

  task automatic cycle();
    @(negedge clk);
    rst             = r_rst;
    rdy             = r_rdy;
    stall_i         = r_stall;
    branch_i        = r_branch;
    branch_target_i = r_tgt;
    if (cmem.exists(cache_rpc_o)) begin
      cache_hit_i  = 1'b1;
      cache_inst_i = cmem[cache_rpc_o];
    end else begin
      cache_hit_i  = 1'b0;
      cache_inst_i = $urandom;
    end
    #1;
    if (r_ack == 2)
      mem_ack_i = mem_req_o ? ($urandom_range(0, 2) == 0)
                            : ($urandom_range(0, 7) == 0);
    else
      mem_ack_i = (r_ack == 1);
    mem_data_i = memb(mem_addr_o);
    #1;
    chk("rpc_align", {30'b0, cache_rpc_o[1:0]}, 32'h0);
    if (!rst) begin
      exp_pc   = 32'h0;
      req_pend = 1'b0;
    end else if (!rdy) begin
      chk("frozen_req_we", {30'b0, mem_req_o, cache_we_o}, 32'h0);
    end else begin
      if (if_valid_o && !stall_i) begin
        chk("acc_pc", if_pc_o, exp_pc);
        chk("acc_inst", if_inst_o, memword(if_pc_o));
        exp_pc = exp_pc + 32'd4;
        n_acc++;
      end
      if (branch_i) exp_pc = {branch_target_i[31:2], 2'b00};
      if (cache_we_o) begin
        chk("wr_data", cache_winst_o, memword(cache_wpc_o));
        cmem[cache_wpc_o] = cache_winst_o;
        we_log.push_back(cache_wpc_o);
      end
      if (mem_req_o) begin
        if (req_pend) chk("addr_hold", mem_addr_o, req_addr);
        req_pend = !mem_ack_i;
        req_addr = mem_addr_o;
        if (mem_ack_i) ack_log.push_back(mem_addr_o);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic go_to(input logic [31:0] t);
    r_branch = 1'b1;
    r_tgt    = t;
    cycle();
    r_branch = 1'b0;
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; stall_i = 1'b0; branch_i = 1'b0;
    branch_target_i = 32'h0; cache_hit_i = 1'b0; cache_inst_i = 32'h0;
    mem_ack_i = 1'b0; mem_data_i = 8'h0;
    r_rst = 1'b0; r_rdy = 1'b1; r_stall = 1'b0; r_branch = 1'b0;
    r_tgt = 32'h0; r_ack = 0;
    exp_pc = 32'h0; req_pend = 1'b0; req_addr = 32'h0;

    repeat (2) cycle();
    chk("rst_valid", {31'b0, if_valid_o}, 32'h0);
    chk("rst_pc", if_pc_o, 32'h0);
    chk("rst_inst", if_inst_o, 32'h0);
    chk("rst_req", {31'b0, mem_req_o}, 32'h0);
    chk("rst_we", {31'b0, cache_we_o}, 32'h0);
    chk("rst_rpc", cache_rpc_o, 32'h0);

    // Cold miss at 0
    r_rst = 1'b1; r_ack = 1;
    ack_log.delete(); we_log.delete();
    repeat (6) cycle();
    chk("t1_latency", {31'b0, if_valid_o}, 32'h0);
    cycle();
    chk("t1_valid", {31'b0, if_valid_o}, 32'h1);
    chk("t1_inst", if_inst_o, 32'h0000_0513);
    chk("t1_pc", if_pc_o, 32'h0);
    chk("t1_next_pc", cache_rpc_o, 32'h4);
    chk("t1_nacks", ack_log.size(), 4);
    foreach (ack_log[i]) chk("t1_addr", ack_log[i], i);
    chk("t1_nwrites", we_log.size(), 1);
    if (we_log.size() > 0) chk("t1_wpc", we_log[0], 32'h0);

    // Hit stream with a stall in the middle
    r_ack = 0;
    for (int a = 32'h100; a <= 32'h10c; a += 4) cmem[a] = memword(a);
    go_to(32'h100);
    chk("t2_br_valid", {31'b0, if_valid_o}, 32'h0);
    chk("t2_br_rpc", cache_rpc_o, 32'h100);
    cycle();
    chk("t2_pc0", if_pc_o, 32'h100);
    cycle();
    chk("t2_pc1", if_pc_o, 32'h104);
    r_stall = 1'b1;
    cycle();
    chk("t2_hold_pc", if_pc_o, 32'h104);
    chk("t2_hold_valid", {31'b0, if_valid_o}, 32'h1);
    r_stall = 1'b0;
    cycle();
    chk("t2_pc2", if_pc_o, 32'h108);

    // Branch during FETCH at cnt=1
    cmem[32'h200] = memword(32'h200);
    go_to(32'h300);
    cycle();
    ack_log.delete(); we_log.delete();
    r_ack = 1;
    cycle();
    r_ack = 0;
    go_to(32'h203);
    chk("t3_pend_req", {31'b0, mem_req_o}, 32'h1);
    chk("t3_pend_addr", mem_addr_o, 32'h301);
    r_ack = 1;
    cycle();
    r_ack = 0;
    chk("t3_rpc", cache_rpc_o, 32'h200);
    chk("t3_valid", {31'b0, if_valid_o}, 32'h0);
    chk("t3_req", {31'b0, mem_req_o}, 32'h0);
    chk("t3_nacks", ack_log.size(), 2);
    chk("t3_nwrites", we_log.size(), 0);
    cycle();
    chk("t3_hit_valid", {31'b0, if_valid_o}, 32'h1);
    chk("t3_hit_pc", if_pc_o, 32'h200);

    // Branch in the WRITE cycle
    go_to(32'h400);
    cycle();
    we_log.delete();
    r_ack = 1;
    repeat (4) cycle();
    r_ack = 0;
    go_to(32'h100);
    chk("t4_nwrites", we_log.size(), 1);
    if (we_log.size() > 0) chk("t4_wpc", we_log[0], 32'h400);
    chk("t4_rpc", cache_rpc_o, 32'h100);
    chk("t4_valid", {31'b0, if_valid_o}, 32'h0);
    cycle();
    chk("t4_pc", if_pc_o, 32'h100);

    // rdy pause mid-FETCH with ack present
    go_to(32'h500);
    cycle();
    r_ack = 1;
    repeat (2) cycle();
    r_rdy = 1'b0;
    repeat (3) cycle();
    chk("t5_req", {31'b0, mem_req_o}, 32'h0);
    chk("t5_addr", mem_addr_o, 32'h502);
    chk("t5_rpc", cache_rpc_o, 32'h500);
    r_rdy = 1'b1;
    we_log.delete();
    repeat (2) cycle();
    r_ack = 0;
    cycle();
    chk("t5_nwrites", we_log.size(), 1);
    if (we_log.size() > 0) chk("t5_wpc", we_log[0], 32'h500);
    cycle();
    chk("t5_pc", if_pc_o, 32'h500);
    chk("t5_inst", if_inst_o, memword(32'h500));

    // Reset mid-FETCH, then a stale ack
    go_to(32'h600);
    cycle();
    r_ack = 1;
    cycle();
    r_rst = 1'b0;
    cycle();
    chk("t6_valid", {31'b0, if_valid_o}, 32'h0);
    chk("t6_pc", if_pc_o, 32'h0);
    chk("t6_inst", if_inst_o, 32'h0);
    chk("t6_req", {31'b0, mem_req_o}, 32'h0);
    chk("t6_we", {31'b0, cache_we_o}, 32'h0);
    chk("t6_rpc", cache_rpc_o, 32'h0);
    r_rst = 1'b1;
    cycle();
    r_ack = 0;
    chk("t6_post_valid", {31'b0, if_valid_o}, 32'h1);
    chk("t6_post_pc", if_pc_o, 32'h0);
    chk("t6_post_inst", if_inst_o, 32'h0000_0513);
    chk("t6_post_req", {31'b0, mem_req_o}, 32'h0);

    // Randomized run against the reference model
    for (int a = 0; a < 256; a += 4)
      if ($urandom_range(0, 1) == 1) cmem[a] = memword(a);
    n_acc = 0;
    for (int c = 0; c < 4000; c++) begin
      r_rst    = ($urandom_range(0, 499) != 0);
      r_rdy    = ($urandom_range(0, 9) != 0);
      r_stall  = ($urandom_range(0, 3) == 0);
      r_branch = ($urandom_range(0, 19) == 0);
      r_tgt    = $urandom_range(0, 255);
      r_ack    = 2;
      cycle();
    end
    chk("progress", {31'b0, n_acc > 100}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- IF-stage front end that owns the PC and looks it up in the instruction cache every cycle.
- On a hit it presents {pc, inst} to the IF/ID register.
- On a miss it reads the 32-bit word from the byte-wide memory controller as 4 little-endian bytes, writes it into the cache, then replays the lookup.
- Handles downstream stall, branch redirect and the global rdy pause.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low; takes effect on the next clk edge while low.
- rdy  in  1  global run enable; when 0 all state is frozen.
- stall_i  in  1  IF/ID not ready; hold the current output.
- branch_i  in  1  redirect pulse from EX.
- branch_target_i  in  32  redirect PC.
- cache_rpc_o  out  32  cache read PC (combinational, equals pc).
- cache_hit_i  in  1  cache hit.
- cache_inst_i  in  32  cache read data.
- cache_we_o  out  1  cache write enable.
- cache_wpc_o  out  32  cache write PC.
- cache_winst_o  out  32  cache write data.
- mem_req_o  out  1  byte read request.
- mem_addr_o  out  32  byte address.
- mem_ack_i  in  1  byte returned this cycle.
- mem_data_i  in  8  returned byte.
- if_pc_o  out  32  fetched PC.
- if_inst_o  out  32  fetched instruction.
- if_valid_o  out  1  if_pc_o/if_inst_o are valid.

Behaviour:
- Reset (rst==0 at edge):
  - pc=RESET_PC, state=LOOKUP, cnt=0, buf=0, redirect_pend=0.
  - if_valid_o=0, if_pc_o=0, if_inst_o=0.
  - mem_req_o=0, cache_we_o=0.
- rdy==0: no register changes; mem_req_o and cache_we_o forced 0.
- cache_rpc_o=pc always. pc[1:0] is always 0; the low 2 bits of branch_target_i are ignored.
- State LOOKUP:
  - hit and !stall_i: if_pc_o<=pc, if_inst_o<=cache_inst_i, if_valid_o<=1, pc<=pc+4 (wraps mod 2^32).
  - hit and stall_i: outputs and pc held.
  - miss and !stall_i: if_valid_o<=0; go FETCH, cnt<=0.
  - miss and stall_i: outputs held; go FETCH. The fill proceeds under stall.
- State FETCH:
  - mem_req_o=1, mem_addr_o=pc+cnt.
  - On mem_ack_i: buf[8*cnt+7:8*cnt]<=mem_data_i, cnt<=cnt+1.
  - Ack with cnt==3: go WRITE.
- State WRITE (1 cycle): cache_we_o=1, cache_wpc_o=pc, cache_winst_o=buf; go LOOKUP. The next cycle hits.
- Miss latency: 4 acks, then 1 WRITE cycle, then 1 LOOKUP cycle, then output registered.
- Branch (priority over stall):
  - LOOKUP: pc<=branch_target_i, if_valid_o<=0. No output capture that cycle.
  - FETCH: one byte is always outstanding. Set redirect_pend and keep mem_req_o high until that byte's ack. On that ack: pc<=redirect target (latched), state<=LOOKUP, no cache write, buf discarded, if_valid_o<=0.
  - FETCH, redirect_pend already set: a second branch overwrites the latched target.
  - WRITE: the write completes for the old pc; pc<=target, if_valid_o<=0.
- Stall never blocks the cache write. Stall only gates output capture and pc increment.
- Memory handshake: mem_addr_o is stable while mem_req_o is high until ack. mem_ack_i outside FETCH is ignored.

Decomposition:
- Shared defines header additions:
  - fetch state encodings IF_LOOKUP/IF_FETCH/IF_WRITE.
  - RESET_PC default.
  - Reuse existing ZeroWord/True_v/False_v.
- No sub-module; byte assembly and FSM are a single module.

Test Plan:
- Reset then cold miss at pc 0, memory bytes 13,05,00,00:
  - mem_addr_o steps 0,1,2,3.
  - cache_we_o one cycle with wpc 0, winst 32'h0000_0513.
  - if_valid_o=1 with if_inst_o 32'h0000_0513 one cycle after WRITE.
  - pc becomes 4.
- Hit stream at pc 0x100,0x104,0x108 with stall_i high in the middle cycle:
  - outputs hold 0x104 for 2 cycles.
  - no PC skipped or duplicated.
- Branch to 0x203 during FETCH at cnt=1:
  - byte 1 ack is accepted and the fill is then abandoned (cnt never reaches 2).
  - no cache_we_o.
  - next cache_rpc_o=0x200.
  - if_valid_o=0 until the 0x200 hit.
- Branch asserted in the WRITE cycle:
  - cache write for the old pc occurs.
  - next lookup at the target.
  - the old instruction is never output.
- rdy=0 for 3 cycles mid-FETCH with an ack pulse present:
  - cnt, buf and pc are unchanged.
  - the fill resumes correctly when rdy=1.
- rst low for 1 cycle mid-FETCH:
  - all outputs 0, pc=RESET_PC, state LOOKUP.
  - the stale ack afterwards is ignored.
